// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction-memory address/data, redirect input and the
// valid/ready hand-off of {pc, instr} to decode.
interface instruction_fetch_if;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;

  modport master (
    output imem_pc, if_valid, if_instr, if_pc,
    input  imem_instr, fetch_en, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_pc, if_valid, if_instr, if_pc,
    output imem_instr, fetch_en, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads the combinational ROM, buffers
// {pc, instr} in a small prefetch FIFO and presents the head to decode.
module instruction_fetch #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter logic [15:0] PC_STEP    = 16'd2,
  parameter int          FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  instruction_fetch_if.master fetch_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   fetch_pc;
  logic [15:0]   pc_mem    [FIFO_DEPTH];
  logic [15:0]   instr_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = (count != '0) & fetch_bus.if_ready;
  assign push = fetch_bus.fetch_en & ~fetch_bus.redirect_valid & (~full | pop);

  // Redirect outranks both push and pop: the whole FIFO is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= PC_RESET;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (fetch_bus.redirect_valid) begin
      fetch_pc <= {fetch_bus.redirect_pc[15:1], 1'b0};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch_pc;
        instr_mem[wr_ptr] <= fetch_bus.imem_instr;
        wr_ptr            <= wr_ptr + 1'b1;
        fetch_pc          <= fetch_pc + PC_STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fetch_bus.imem_pc  = fetch_pc;
  assign fetch_bus.if_valid = (count != '0);
  assign fetch_bus.if_instr = instr_mem[rd_ptr];
  assign fetch_bus.if_pc    = pc_mem[rd_ptr];

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(FIFO_DEPTH));
  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    fetch_pc[0] == 1'b0);
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, checked
// by a queue-based reference model and a negedge monitor.
module tb_instruction_fetch;
  localparam int DEPTH = 2;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom [256];

  instruction_fetch_if bus ();
  instruction_fetch_if bus_w ();

  instruction_fetch #(.PC_RESET(16'h0000), .PC_STEP(16'd2), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  instruction_fetch #(.PC_RESET(16'hFFFE), .PC_STEP(16'd2), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus_w)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr   = rom[bus.imem_pc[8:1]];
  assign bus_w.imem_instr = rom[bus_w.imem_pc[8:1]];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a plain queue of expected {pc, instr}.
  entry_t      exp_q[$];
  logic [15:0] model_pc = 16'h0000;
  logic        accepted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int occ;
    if (!rst_n) begin
      exp_q.delete();
      model_pc = 16'h0000;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      model_pc = bus.redirect_pc & 16'hFFFE;
    end else begin
      occ = exp_q.size() + (accepted ? 1 : 0);
      if (bus.fetch_en && (occ < DEPTH || accepted)) begin
        exp_q.push_back('{pc: model_pc, instr: rom[model_pc[8:1]]});
        model_pc = model_pc + 16'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      chk("mon_valid", 16'(bus.if_valid), 16'd1);
      chk("mon_pc", bus.if_pc, exp_q[0].pc);
      chk("mon_instr", bus.if_instr, exp_q[0].instr);
      if (rst_n && bus.if_ready) begin
        void'(exp_q.pop_front());
        accepted = 1'b1;
      end else begin
        accepted = 1'b0;
      end
    end else begin
      chk("mon_valid", 16'(bus.if_valid), 16'd0);
      accepted = 1'b0;
    end
    chk("mon_imem_pc", bus.imem_pc, model_pc);
  end

  task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [15:0] rpc);
    bus.fetch_en       = fe;
    bus.if_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wp;
    logic [15:0] frozen;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    bus_w.fetch_en       = 1'b1;
    bus_w.if_ready       = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc    = 16'h0000;

    // reset state and straight-line fetch, plus wrap on the FFFE instance
    repeat (2) cyc();
    chk("rst_valid", 16'(bus.if_valid), 16'd0);
    chk("rst_imem_pc", bus.imem_pc, 16'h0000);
    chk("rst_if_pc", bus.if_pc, 16'h0000);
    chk("rst_if_instr", bus.if_instr, 16'h0000);
    chk("rst_wrap_imem_pc", bus_w.imem_pc, 16'hFFFE);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("seq_pc", bus.if_pc, 16'(2 * k));
      chk("seq_instr", bus.if_instr, rom[k]);
      wp = 16'hFFFE + 16'(2 * k);
      chk("wrap_valid", 16'(bus_w.if_valid), 16'd1);
      chk("wrap_pc", bus_w.if_pc, wp);
      chk("wrap_instr", bus_w.if_instr, rom[wp[8:1]]);
    end

    // backpressure from reset
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    #2 rst_n = 1'b1;
    repeat (3) cyc();
    chk("bp_imem_pc", bus.imem_pc, 16'h0004);
    chk("bp_if_pc", bus.if_pc, 16'h0000);
    bus.if_ready = 1'b1;
    cyc();
    chk("bp_drain1", bus.if_pc, 16'h0002);
    cyc();
    chk("bp_drain2", bus.if_pc, 16'h0004);

    // redirect while full
    bus.if_ready = 1'b0;
    repeat (3) cyc();
    drive(1'b1, 1'b0, 1'b1, 16'h0019);
    cyc();
    chk("redir_valid", 16'(bus.if_valid), 16'd0);
    chk("redir_imem_pc", bus.imem_pc, 16'h0018);
    bus.redirect_valid = 1'b0;
    cyc();
    chk("redir_pc", bus.if_pc, 16'h0018);
    chk("redir_instr", bus.if_instr, rom[12]);

    // fetch_en low: PC frozen, FIFO drains
    cyc();
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    frozen = model_pc;
    repeat (3) begin
      cyc();
      chk("hold_imem_pc", bus.imem_pc, frozen);
    end
    chk("hold_empty", 16'(bus.if_valid), 16'd0);
    bus.fetch_en = 1'b1;
    cyc();
    chk("resume_pc", bus.if_pc, frozen);

    // async reset between edges with two entries held
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("areset_valid", 16'(bus.if_valid), 16'd0);
    chk("areset_imem_pc", bus.imem_pc, 16'h0000);
    cyc();
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    cyc();
    chk("areset_first_pc", bus.if_pc, 16'h0000);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] rpc;
      rpc = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rpc = 16'hFFFA + 16'($urandom_range(0, 5));
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, rpc);
      cyc();
    end

    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
